// File: rtl/mipi_pkg.sv
// mipi_pkg: shared state encoding, sync byte and LP line codes for the MIPI deserializer
package mipi_pkg;

    typedef enum logic [2:0] {
        ST_STOP,
        ST_HS_RQST,
        ST_SYNC,
        ST_HST,
        ST_WAIT
    } state_t;

    localparam logic [7:0] SYNC_BYTE = 8'hB8;

    // LP codes are {dp, dn}
    localparam logic [1:0] LP11 = 2'b11;
    localparam logic [1:0] LP01 = 2'b01;
    localparam logic [1:0] LP00 = 2'b00;
    localparam logic [1:0] LP10 = 2'b10;

endpackage

// File: rtl/mipi_lp_filter.sv
// mipi_lp_filter: 2-flop synchronizer plus LP_FILTER-cycle stability filter for the LP line pair
module mipi_lp_filter import mipi_pkg::*; #(
    parameter int LP_FILTER = 2
) (
    input  logic       clk,
    input  logic       resetb,
    input  logic [1:0] lp_in,
    output logic [1:0] lp
);

    localparam int CW = $clog2(LP_FILTER + 1) + 1;

    logic [1:0]    s1, s2, cand;
    logic [CW-1:0] cnt, run;

    // length of the current run of identical synchronized codes, saturating at LP_FILTER
    always_comb run = (s2 != cand) ? CW'(1) : (cnt >= CW'(LP_FILTER)) ? cnt : cnt + 1'b1;

    // synchronizer, run tracker and accepted code; everything idles at LP-11
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            s1   <= LP11;
            s2   <= LP11;
            cand <= LP11;
            cnt  <= CW'(LP_FILTER);
            lp   <= LP11;
        end else begin
            s1   <= lp_in;
            s2   <= s1;
            cand <= s2;
            cnt  <= run;
            if (run >= CW'(LP_FILTER)) lp <= s2;
        end
    end

endmodule

// File: rtl/mipi_phy_des.sv
// mipi_phy_des: HS lane deserializer with LP state tracking, sync search and byte assembly
// Build option MIPI_DES_TRAIL_STRIP_EN: hold each byte one byte period and drop the final trail byte.
module mipi_phy_des import mipi_pkg::*; #(
    parameter int LP_FILTER    = 2,
    parameter int SYNC_TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       resetb,
    input  logic       enable,
    input  logic       mdp_lp,
    input  logic       mdn_lp,
    input  logic       hs_bit,
    input  logic       bit_valid,
    output logic [7:0] data,
    output logic       we,
    output logic       sot,
    output logic       eot,
    output logic       hs_active,
    output logic       sync_err
);

    localparam int TW = $clog2(SYNC_TIMEOUT + 1) + 1;

    state_t        state, state_nx;
    logic [1:0]    lp;
    logic [7:0]    sr, sr_sh;
    logic [2:0]    bcnt;
    logic [TW-1:0] tcnt;
    logic          shift, clr, byte_done, sot_nx, eot_nx, err_nx;

    mipi_lp_filter #(.LP_FILTER(LP_FILTER)) u_lp (
        .clk    (clk),
        .resetb (resetb),
        .lp_in  ({mdp_lp, mdn_lp}),
        .lp     (lp)
    );

    assign sr_sh     = {hs_bit, sr[7:1]};
    assign shift     = enable && bit_valid && (state == ST_SYNC || state == ST_HST);
    assign hs_active = state == ST_HST;

    // state register
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) state <= ST_STOP;
        else         state <= state_nx;
    end

    // next state and single-cycle event decode
    always_comb begin
        state_nx  = state;
        clr       = 1'b0;
        byte_done = 1'b0;
        sot_nx    = 1'b0;
        eot_nx    = 1'b0;
        err_nx    = 1'b0;
        if (!enable) begin
            state_nx = ST_STOP;
        end else begin
            case (state)
                ST_STOP: if (lp == LP01) state_nx = ST_HS_RQST;
                ST_HS_RQST: begin
                    if (lp == LP00) begin
                        state_nx = ST_SYNC;
                        clr      = 1'b1;
                    end else if (lp == LP11) begin
                        state_nx = ST_STOP;
                    end else if (lp == LP10) begin
                        state_nx = ST_WAIT;
                    end
                end
                ST_SYNC: begin
                    if (lp == LP11) begin
                        state_nx = ST_STOP;
                    end else if (bit_valid && tcnt >= TW'(7) && sr_sh == SYNC_BYTE) begin
                        state_nx = ST_HST;
                        sot_nx   = 1'b1;
                    end else if (bit_valid && tcnt >= TW'(SYNC_TIMEOUT - 1)) begin
                        state_nx = ST_WAIT;
                        err_nx   = 1'b1;
                    end
                end
                ST_HST: begin
                    byte_done = bit_valid && bcnt == 3'd7;
                    // a byte completing alongside LP-11 goes out first; eot follows next cycle
                    if (lp == LP11 && !byte_done) begin
                        state_nx = ST_STOP;
                        eot_nx   = 1'b1;
                    end
                end
                ST_WAIT: if (lp == LP11) state_nx = ST_STOP;
                default: state_nx = ST_STOP;
            endcase
        end
    end

    // shift register, bit counters and registered status pulses
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            sr       <= 8'h00;
            bcnt     <= 3'd0;
            tcnt     <= '0;
            sot      <= 1'b0;
            eot      <= 1'b0;
            sync_err <= 1'b0;
        end else begin
            sot      <= sot_nx;
            eot      <= eot_nx;
            sync_err <= err_nx;
            if (clr) begin
                sr   <= 8'h00;
                bcnt <= 3'd0;
                tcnt <= '0;
            end else if (shift) begin
                sr <= sr_sh;
                if (state == ST_SYNC) tcnt <= (tcnt >= TW'(SYNC_TIMEOUT)) ? tcnt : tcnt + 1'b1;
                else                  bcnt <= bcnt + 3'd1;
            end
        end
    end

`ifdef MIPI_DES_TRAIL_STRIP_EN
    logic [7:0] held;
    logic       held_v;

    // one-byte buffer: a byte goes out only once its successor completes, so the last one never does
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            data   <= 8'h00;
            we     <= 1'b0;
            held   <= 8'h00;
            held_v <= 1'b0;
        end else begin
            we     <= byte_done && held_v;
            if (byte_done && held_v) data <= held;
            if (byte_done) held <= sr_sh;
            held_v <= (state_nx == ST_HST) && (held_v || byte_done);
        end
    end
`else
    // every completed byte goes out one cycle after its last bit
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            data <= 8'h00;
            we   <= 1'b0;
        end else begin
            we <= byte_done;
            if (byte_done) data <= sr_sh;
        end
    end
`endif

endmodule

// File: tb/tb_mipi_phy_des.sv
// tb_mipi_phy_des: randomized and directed self-checking bench for mipi_phy_des
module tb_mipi_phy_des;

    localparam int LP_FILTER    = 2;
    localparam int SYNC_TIMEOUT = 64;
`ifdef MIPI_DES_TRAIL_STRIP_EN
    localparam int STRIP = 1;
`else
    localparam int STRIP = 0;
`endif
    localparam int EOT_LAT = 2 + LP_FILTER + 1;

    logic       clk = 1'b0;
    logic       resetb, enable, mdp_lp, mdn_lp, hs_bit, bit_valid;
    logic [7:0] data;
    logic       we, sot, eot, hs_active, sync_err;

    int checks = 0, failures = 0;
    int cyc = 0, nsent = 0, lp11_cyc = 0;
    int n_sot = 0, n_eot = 0, n_err = 0, eot_cyc = 0, err_at = 0;
    logic [7:0] got[$];
    int         got_at[$];
    bit         bits[$];
    logic [7:0] exp_q[$];
    int         exp_at[$];
    bit         exp_sot, exp_err;

    mipi_phy_des #(.LP_FILTER(LP_FILTER), .SYNC_TIMEOUT(SYNC_TIMEOUT)) dut (
        .clk       (clk),
        .resetb    (resetb),
        .enable    (enable),
        .mdp_lp    (mdp_lp),
        .mdn_lp    (mdn_lp),
        .hs_bit    (hs_bit),
        .bit_valid (bit_valid),
        .data      (data),
        .we        (we),
        .sot       (sot),
        .eot       (eot),
        .hs_active (hs_active),
        .sync_err  (sync_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // observe outputs mid-cycle, away from the active edge
    always @(negedge clk) begin
        if (we) begin
            got.push_back(data);
            got_at.push_back(nsent);
        end
        if (sot) n_sot++;
        if (eot) begin
            n_eot++;
            eot_cyc = cyc;
        end
        if (sync_err) begin
            n_err++;
            err_at = nsent;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_lp(input logic [1:0] v, input int n);
        {mdp_lp, mdn_lp} = v;
        step(n);
    endtask

    task automatic send_bit(input bit b);
        hs_bit    = b;
        bit_valid = 1'b1;
        @(posedge clk);
        nsent++;
        #1;
        bit_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            bit_valid = 1'b0;
            hs_bit    = 1'($urandom_range(0, 1));
            step(1);
        end
    endtask

    function automatic void push_byte(input logic [7:0] b);
        for (int j = 0; j < 8; j++) bits.push_back(b[j]);
    endfunction

    // reference: find the first 8-bit window equal to B8 (LSB-first) within the timeout,
    // then cut the rest of the stream into whole bytes; strip mode loses the last one
    function automatic void model();
        logic [7:0] w, b;
        int s, nb;
        w = 8'h00;
        s = -1;
        exp_err = 1'b0;
        exp_q.delete();
        exp_at.delete();
        for (int i = 0; i < bits.size(); i++) begin
            w = {bits[i], w[7:1]};
            if (i >= 7 && w == 8'hB8) begin
                s = i;
                break;
            end
            if (i == SYNC_TIMEOUT - 1) begin
                exp_err = 1'b1;
                break;
            end
        end
        exp_sot = s >= 0;
        if (s >= 0) begin
            nb = (bits.size() - s - 1) / 8;
            for (int k = 0; k < nb - STRIP; k++) begin
                for (int j = 0; j < 8; j++) b[j] = bits[s + 1 + 8 * k + j];
                exp_q.push_back(b);
                exp_at.push_back(s + 1 + 8 * (k + 1 + STRIP));
            end
        end
    endfunction

    // LP-11 idle, LP-01, LP-00, HS bits, then LP-11; gaps: 0 none, 1 random, 2 every other cycle
    task automatic drive_packet(input int gaps);
        set_lp(2'b11, 6);
        set_lp(2'b01, 8);
        set_lp(2'b00, 8);
        foreach (bits[i]) begin
            if (gaps == 2) idle(1);
            else if (gaps == 1 && $urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
            send_bit(bits[i]);
        end
        bit_valid        = 1'b0;
        {mdp_lp, mdn_lp} = 2'b11;
        lp11_cyc         = cyc;
        step(14);
    endtask

    task automatic test_reset();
        resetb           = 1'b0;
        enable           = 1'b1;
        {mdp_lp, mdn_lp} = 2'b11;
        hs_bit           = 1'b0;
        bit_valid        = 1'b0;
        step(3);
        checks++; if (data !== 8'h00)  begin failures++; $display("FAIL reset_data: got %0h expected 0", data); end
        checks++; if (we !== 1'b0)     begin failures++; $display("FAIL reset_we: got %0b expected 0", we); end
        checks++; if (sot !== 1'b0)    begin failures++; $display("FAIL reset_sot: got %0b expected 0", sot); end
        checks++; if (eot !== 1'b0)    begin failures++; $display("FAIL reset_eot: got %0b expected 0", eot); end
        checks++; if (sync_err !== 1'b0) begin failures++; $display("FAIL reset_sync_err: got %0b expected 0", sync_err); end
        checks++; if (hs_active !== 1'b0) begin failures++; $display("FAIL reset_hs_active: got %0b expected 0", hs_active); end
        resetb = 1'b1;
        idle(4);
        checks++; if ({we, sot, eot, sync_err, hs_active} !== 5'b0) begin
            failures++; $display("FAIL post_reset_idle: got %05b expected 00000", {we, sot, eot, sync_err, hs_active});
        end
    endtask

    task automatic test_packets();
        int b_got, b_sot, b_eot, b_err, b_ns, nb;
        for (int sc = 0; sc < 15; sc++) begin
            bits.delete();
            if (sc == 0 || sc == 2) begin
                push_byte(8'hB8); push_byte(8'h11); push_byte(8'h22); push_byte(8'h33);
                if (sc == 2) begin bits.push_back(1'b1); bits.push_back(1'b0); bits.push_back(1'b1); end
            end else if (sc == 1) begin
                for (int i = 0; i < 16; i++) bits.push_back(1'b0);
                push_byte(8'hB8); push_byte(8'h11); push_byte(8'h22); push_byte(8'h33);
            end else begin
                for (int i = $urandom_range(0, 20); i > 0; i--) bits.push_back(1'($urandom_range(0, 1)));
                push_byte(8'hB8);
                nb = $urandom_range(1, 5);
                for (int i = 0; i < nb; i++) push_byte(8'($urandom));
                for (int i = $urandom_range(0, 7); i > 0; i--) bits.push_back(1'($urandom_range(0, 1)));
            end
            model();
            b_got = got.size(); b_sot = n_sot; b_eot = n_eot; b_err = n_err; b_ns = nsent;
            drive_packet(sc == 1 ? 2 : (sc >= 3 ? 1 : 0));
            checks++;
            if (got.size() - b_got !== exp_q.size()) begin
                failures++; $display("FAIL pkt%0d_byte_count: got %0d expected %0d", sc, got.size() - b_got, exp_q.size());
            end
            for (int k = 0; k < exp_q.size(); k++) begin
                checks++;
                if (b_got + k >= got.size() || got[b_got + k] !== exp_q[k] || got_at[b_got + k] - b_ns !== exp_at[k]) begin
                    failures++;
                    if (b_got + k < got.size())
                        $display("FAIL pkt%0d_byte%0d: got %0h at bit %0d expected %0h at bit %0d", sc, k,
                                 got[b_got + k], got_at[b_got + k] - b_ns, exp_q[k], exp_at[k]);
                    else
                        $display("FAIL pkt%0d_byte%0d: got none expected %0h", sc, k, exp_q[k]);
                end
            end
            checks++; if (n_sot - b_sot !== int'(exp_sot)) begin
                failures++; $display("FAIL pkt%0d_sot: got %0d expected %0d", sc, n_sot - b_sot, exp_sot);
            end
            checks++; if (n_eot - b_eot !== int'(exp_sot)) begin
                failures++; $display("FAIL pkt%0d_eot: got %0d expected %0d", sc, n_eot - b_eot, exp_sot);
            end
            checks++; if (n_err - b_err !== int'(exp_err)) begin
                failures++; $display("FAIL pkt%0d_sync_err: got %0d expected %0d", sc, n_err - b_err, exp_err);
            end
            if (exp_sot && n_eot > b_eot) begin
                checks++; if (eot_cyc - lp11_cyc !== EOT_LAT) begin
                    failures++; $display("FAIL pkt%0d_eot_latency: got %0d expected %0d", sc, eot_cyc - lp11_cyc, EOT_LAT);
                end
            end
        end
    endtask

    task automatic test_timeout();
        int b_got, b_sot, b_eot, b_err, b_ns;
        bits.delete();
        for (int i = 0; i < 8; i++) push_byte(8'h55);
        b_got = got.size(); b_sot = n_sot; b_eot = n_eot; b_err = n_err; b_ns = nsent;
        set_lp(2'b11, 6);
        set_lp(2'b01, 8);
        set_lp(2'b00, 8);
        foreach (bits[i]) send_bit(bits[i]);
        idle(2);
        checks++; if (n_err - b_err !== 1) begin failures++; $display("FAIL timeout_err_count: got %0d expected 1", n_err - b_err); end
        checks++; if (err_at - b_ns !== SYNC_TIMEOUT) begin
            failures++; $display("FAIL timeout_err_bit: got %0d expected %0d", err_at - b_ns, SYNC_TIMEOUT);
        end
        checks++; if (hs_active !== 1'b0) begin failures++; $display("FAIL timeout_hs_active: got %0b expected 0", hs_active); end
        set_lp(2'b01, 8);
        set_lp(2'b00, 8);
        bits.delete();
        push_byte(8'hB8); push_byte(8'h11);
        foreach (bits[i]) send_bit(bits[i]);
        idle(2);
        checks++; if (n_sot - b_sot !== 0) begin failures++; $display("FAIL timeout_wait_sot: got %0d expected 0", n_sot - b_sot); end
        checks++; if (got.size() - b_got !== 0) begin failures++; $display("FAIL timeout_wait_we: got %0d expected 0", got.size() - b_got); end
        set_lp(2'b11, 14);
        checks++; if (n_eot - b_eot !== 0) begin failures++; $display("FAIL timeout_eot: got %0d expected 0", n_eot - b_eot); end
    endtask

    task automatic test_glitch();
        int b_got, b_sot, b_eot;
        b_got = got.size(); b_sot = n_sot; b_eot = n_eot;
        set_lp(2'b11, 6);
        set_lp(2'b01, 1);
        set_lp(2'b11, 6);
        set_lp(2'b00, 8);
        bits.delete();
        push_byte(8'hB8); push_byte(8'h5A); push_byte(8'hC3);
        foreach (bits[i]) send_bit(bits[i]);
        idle(2);
        checks++; if (hs_active !== 1'b0) begin failures++; $display("FAIL glitch_hs_active: got %0b expected 0", hs_active); end
        set_lp(2'b11, 14);
        checks++; if (n_sot - b_sot !== 0) begin failures++; $display("FAIL glitch_sot: got %0d expected 0", n_sot - b_sot); end
        checks++; if (got.size() - b_got !== 0) begin failures++; $display("FAIL glitch_we: got %0d expected 0", got.size() - b_got); end
        checks++; if (n_eot - b_eot !== 0) begin failures++; $display("FAIL glitch_eot: got %0d expected 0", n_eot - b_eot); end
    endtask

    task automatic test_enable();
        int b_got, b_sot, b_eot, b_ns;
        b_got = got.size(); b_sot = n_sot; b_eot = n_eot; b_ns = nsent;
        set_lp(2'b11, 6);
        set_lp(2'b01, 8);
        set_lp(2'b00, 8);
        bits.delete();
        push_byte(8'hB8); push_byte(8'h11);
        for (int i = 0; i < 4; i++) bits.push_back(1'($urandom_range(0, 1)));
        foreach (bits[i]) send_bit(bits[i]);
        enable = 1'b0;
        idle(2);
        checks++; if (hs_active !== 1'b0) begin failures++; $display("FAIL enable_hs_active: got %0b expected 0", hs_active); end
        enable = 1'b1;
        for (int i = 0; i < 12; i++) send_bit(1'($urandom_range(0, 1)));
        set_lp(2'b11, 14);
        checks++; if (got.size() - b_got !== 1 - STRIP) begin
            failures++; $display("FAIL enable_we_count: got %0d expected %0d", got.size() - b_got, 1 - STRIP);
        end
        if (STRIP == 0 && got.size() > b_got) begin
            checks++; if (got[b_got] !== 8'h11 || got_at[b_got] - b_ns !== 16) begin
                failures++; $display("FAIL enable_byte: got %0h at bit %0d expected 11 at bit 16", got[b_got], got_at[b_got] - b_ns);
            end
        end
        checks++; if (n_sot - b_sot !== 1) begin failures++; $display("FAIL enable_sot: got %0d expected 1", n_sot - b_sot); end
        checks++; if (n_eot - b_eot !== 0) begin failures++; $display("FAIL enable_eot: got %0d expected 0", n_eot - b_eot); end
    endtask

    task automatic test_reset_mid();
        int b_got, b_sot, b_eot, b_err;
        b_got = got.size();
        set_lp(2'b11, 6);
        set_lp(2'b01, 8);
        set_lp(2'b00, 8);
        bits.delete();
        push_byte(8'hB8); push_byte(8'h11); push_byte(8'h22);
        foreach (bits[i]) send_bit(bits[i]);
        idle(1);
        checks++; if (hs_active !== 1'b1) begin failures++; $display("FAIL rstmid_hs_active: got %0b expected 1", hs_active); end
        checks++; if (got.size() - b_got !== 2 - STRIP) begin
            failures++; $display("FAIL rstmid_we_count: got %0d expected %0d", got.size() - b_got, 2 - STRIP);
        end
        #2;
        resetb = 1'b0;
        #1;
        checks++; if ({data, we, sot, eot, sync_err, hs_active} !== 13'b0) begin
            failures++; $display("FAIL rstmid_outputs: got %0h expected 0", {data, we, sot, eot, sync_err, hs_active});
        end
        step(2);
        resetb = 1'b1;
        b_got = got.size(); b_sot = n_sot; b_eot = n_eot; b_err = n_err;
        for (int i = 0; i < 16; i++) send_bit(1'($urandom_range(0, 1)));
        set_lp(2'b11, 14);
        checks++; if (got.size() - b_got !== 0) begin failures++; $display("FAIL rstmid_we_after: got %0d expected 0", got.size() - b_got); end
        checks++; if (n_eot - b_eot !== 0) begin failures++; $display("FAIL rstmid_eot_after: got %0d expected 0", n_eot - b_eot); end
        checks++; if (n_sot - b_sot + n_err - b_err !== 0) begin
            failures++; $display("FAIL rstmid_pulses_after: got %0d expected 0", n_sot - b_sot + n_err - b_err);
        end
    endtask

    initial begin
        test_reset();
        test_packets();
        test_timeout();
        test_glitch();
        test_enable();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
